score_display_ctrl: RTL

//  Converts a binary score to BCD digits with a sequential double-dabble engine.

---
 rtl/score_display_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/score_display_ctrl.sv
// Score display controller: sequential double-dabble binary->BCD plus a 2-stage glyph render pipeline.
// Optional leading-zero blanking is compiled in with `define LEADING_ZERO_BLANK_EN.
module score_display_ctrl #(
  parameter int BIN_W      = 14,
  parameter int NUM_DIGITS = 4,
  parameter int ORIGIN_X   = 16,
  parameter int ORIGIN_Y   = 16,
  parameter int SCALE_LOG2 = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [BIN_W-1:0] score_i,
  input  logic             score_valid_i,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  input  logic             pix_de,
  output logic [3:0]       glyph_digit_o,
  output logic [2:0]       glyph_x_o,
  output logic [2:0]       glyph_y_o,
  input  logic             glyph_bit_i,
  output logic             score_pix_o,
  output logic             busy_o
);

  // state  | meaning
  // IDLE   | waiting for a score strobe
  // SHIFT  | BIN_W double-dabble iterations
  // COMMIT | copy working BCD to displayed digits
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  localparam int          BCD_W    = 4 * NUM_DIGITS;
  localparam int          WIN_W    = (NUM_DIGITS * 8) << SCALE_LOG2;
  localparam int          WIN_H    = 8 << SCALE_LOG2;
  localparam logic [31:0] MAX_VAL  = 32'(10**NUM_DIGITS - 1);
  localparam logic [4:0]  CNT_LOAD = 5'(BIN_W - 1);

  state_t           state;
  logic [4:0]       cnt;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;
  logic [BIN_W-1:0] pend_val;
  logic             pend_q;
  logic [3:0]       disp [NUM_DIGITS];

  function automatic logic [BIN_W-1:0] sat(input logic [BIN_W-1:0] v);
    if (32'(v) > MAX_VAL) return MAX_VAL[BIN_W-1:0];
    else                  return v;
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      pend_val <= '0;
      pend_q   <= 1'b0;
      busy_o   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (score_valid_i) begin
            bin_q  <= sat(score_i);
            bcd_q  <= '0;
            cnt    <= CNT_LOAD;
            busy_o <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (score_valid_i) begin
            pend_val <= score_i;
            pend_q   <= 1'b1;
          end
          {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
          if (cnt == 5'd0) state <= COMMIT;
          else             cnt   <= cnt - 5'd1;
        end
        COMMIT: begin
          for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= bcd_q[4*i +: 4];
          pend_q <= 1'b0;
          // A strobe landing on the commit cycle is newer than anything pending.
          if (score_valid_i || pend_q) begin
            bin_q <= sat(score_valid_i ? score_i : pend_val);
            bcd_q <= '0;
            cnt   <= CNT_LOAD;
            state <= SHIFT;
          end else begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [10:0] rx, ry, idx_full;
  logic        in_win;
  logic [3:0]  digit_sel;
  logic        blank_sel;
  logic        in_win_d;
  logic        blank_d;

  // 11-bit subtraction: a coordinate left of / above the origin sets bit 10.
  assign rx       = {1'b0, pix_x} - 11'(ORIGIN_X);
  assign ry       = {1'b0, pix_y} - 11'(ORIGIN_Y);
  assign idx_full = rx >> (SCALE_LOG2 + 3);
  assign in_win   = pix_de && !rx[10] && (rx < 11'(WIN_W)) && !ry[10] && (ry < 11'(WIN_H));

  always_comb begin
    digit_sel = 4'd0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (idx_full == 11'(j)) digit_sel = disp[NUM_DIGITS-1-j];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_run;
  always_comb begin
    blank_sel = 1'b0;
    zero_run  = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      zero_run = zero_run && (disp[NUM_DIGITS-1-j] == 4'd0);
      if (idx_full == 11'(j)) blank_sel = zero_run && (j != NUM_DIGITS - 1);
    end
  end
`else
  assign blank_sel = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      glyph_digit_o <= 4'd0;
      glyph_x_o     <= 3'd0;
      glyph_y_o     <= 3'd0;
      in_win_d      <= 1'b0;
      blank_d       <= 1'b0;
      score_pix_o   <= 1'b0;
    end else begin
      in_win_d <= in_win;
      if (in_win) begin
        glyph_digit_o <= digit_sel;
        glyph_x_o     <= rx[SCALE_LOG2 +: 3];
        glyph_y_o     <= ry[SCALE_LOG2 +: 3];
        blank_d       <= blank_sel;
      end
      score_pix_o <= in_win_d & glyph_bit_i & ~blank_d;
    end
  end

endmodule
